// File: rtl/instr_queue.sv
// instr_queue: multi-source show-ahead instruction FIFO with sticky overflow/underflow/select-error flags
module instr_queue #(
  parameter int WIDTH = 12,
  parameter int NSRC = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ld,
  input  logic [$clog2(NSRC)-1:0]      sel,
  input  logic [NSRC*WIDTH-1:0]        in,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             result,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf,
  output logic                         unf,
  output logic                         sel_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic sel_ok, pop_ok, push_ok;
  logic [NSRC*WIDTH-1:0] src;
  assign sel_ok = int'(sel) < NSRC;
  assign valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign pop_ok = pop && !flush && valid;
  assign push_ok = ld && !flush && sel_ok && (!full || pop_ok);
  assign src = in >> (int'(sel) * WIDTH);
  assign result = valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= src[WIDTH-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      sel_err <= 1'b0;
    end else if (flush) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (pop_ok) rp <= rp + AW'(1);
      if (push_ok) wp <= wp + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
      ovf <= ovf | (ld && sel_ok && full && !pop_ok);
      unf <= unf | (pop && !valid);
      sel_err <= sel_err | (ld && !sel_ok);
    end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: randomized scoreboard bench for instr_queue against a queue-based reference model
module tb_instr_queue;
  typedef struct packed {
    logic [11:0] r;
    logic v;
    logic f;
    logic [2:0] c;
    logic o;
    logic u;
    logic s;
  } snap_t;
  logic clk = 1'b0;
  logic reset, ld, pop, flush;
  logic [1:0] sel;
  logic [35:0] in;
  logic [11:0] result;
  logic valid, full, ovf, unf, sel_err;
  logic [2:0] count;
  int nvec = 0;
  int nerr = 0;
  snap_t exp_q[$];
  snap_t e;
  logic [11:0] mq[$];
  bit mo, mu, ms;
  instr_queue #(.WIDTH(12), .NSRC(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ld(ld), .sel(sel), .in(in), .pop(pop), .flush(flush),
    .result(result), .valid(valid), .full(full), .count(count),
    .ovf(ovf), .unf(unf), .sel_err(sel_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
    nvec++;
    if (a !== x) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, x, $time);
    end
  endtask
  task automatic chk_all(input snap_t x);
    chk("result", 32'(result), 32'(x.r));
    chk("valid", 32'(valid), 32'(x.v));
    chk("full", 32'(full), 32'(x.f));
    chk("count", 32'(count), 32'(x.c));
    chk("ovf", 32'(ovf), 32'(x.o));
    chk("unf", 32'(unf), 32'(x.u));
    chk("sel_err", 32'(sel_err), 32'(x.s));
  endtask
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk_all(e);
    end
  task automatic cyc(input bit l, input logic [1:0] s, input logic [11:0] w, input bit p, input bit f);
    logic [35:0] v;
    snap_t x;
    v = 36'({$urandom(), $urandom()});
    if (s < 2'd3) v[s*12 +: 12] = w;
    ld = l;
    sel = s;
    in = v;
    pop = p;
    flush = f;
    @(posedge clk);
    if (f) mq.delete();
    else begin
      if (p && mq.size() == 0) mu = 1;
      if (l && s >= 2'd3) ms = 1;
      if (p && mq.size() > 0) void'(mq.pop_front());
      if (l && s < 2'd3) begin
        if (mq.size() < 4) mq.push_back(w);
        else mo = 1;
      end
    end
    x.v = mq.size() != 0;
    x.r = x.v ? mq[0] : 12'h000;
    x.f = mq.size() == 4;
    x.c = 3'(mq.size());
    x.o = mo;
    x.u = mu;
    x.s = ms;
    exp_q.push_back(x);
    @(negedge clk);
  endtask
  task automatic push(input logic [1:0] s, input logic [11:0] w);
    cyc(1, s, w, 0, 0);
  endtask
  task automatic pop1();
    cyc(0, 2'd0, 12'h000, 1, 0);
  endtask
  task automatic rst_pulse();
    #2 reset = 1'b1;
    #1 chk_all('0);
    mq.delete();
    mo = 0;
    mu = 0;
    ms = 0;
    #1 reset = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    ld = 0;
    pop = 0;
    flush = 0;
    sel = 0;
    in = '0;
    #3 chk_all('0);
    @(negedge clk);
    reset = 1'b0;
    push(2'd0, 12'h123);
    push(2'd1, 12'hABC);
    pop1();
    pop1();
    for (int i = 1; i <= 5; i++) push(2'($urandom_range(0, 2)), 12'(i));
    for (int i = 0; i < 5; i++) pop1();
    rst_pulse();
    for (int i = 1; i <= 4; i++) push(2'($urandom_range(0, 2)), 12'(i));
    cyc(1, 2'd2, 12'h005, 1, 0);
    for (int i = 0; i < 4; i++) pop1();
    rst_pulse();
    cyc(1, 2'd1, 12'h0F0, 1, 0);
    rst_pulse();
    push(2'd3, 12'h777);
    for (int i = 0; i < 3; i++) push(2'(i), 12'h0A0 + 12'(i));
    cyc(1, 2'd0, 12'h0FF, 0, 1);
    push(2'd1, 12'h211);
    push(2'd2, 12'h222);
    rst_pulse();
    push(2'd0, 12'h301);
    push(2'd1, 12'h302);
    for (int i = 3; i <= 6; i++) cyc(1, 2'($urandom_range(0, 2)), 12'h300 + 12'(i), 1, 0);
    pop1();
    pop1();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 6,
          $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2)),
          12'($urandom()), $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
      if ($urandom_range(0, 99) == 0) rst_pulse();
    end
    @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
